ft_cell_selector: RTL
=====================

// Module: ft_cell_selector
// PURPOSE
//  Consumer of the per-frame fingertip position stream (X/Y + one-cycle valid per frame).
//  Maps each fingertip sample onto a 3x3 board grid and debounces it with a dwell counter.
//  Emits one cell-select event per deliberate hover, using a valid/ready handshake to game logic.
//  Sits between fingertip position detection and the tic-tac-toe game controller.
// PARAMETERS
//  SCREEN_W      640  X >= SCREEN_W means no fingertip (lost frame)
//  SCREEN_H      480  Y >= SCREEN_H means no fingertip (lost frame)
//  COL_B0 / COL_B1  213 / 426  column edges: X<COL_B0 -> col0, X<COL_B1 -> col1, else col2
//  ROW_B0 / ROW_B1  160 / 320  row edges, same rule on Y
//  DWELL_FRAMES  15   consecutive same-cell frames needed to select (1..255)
//  LOST_FRAMES   2    consecutive lost frames tolerated without dropping the candidate (0..15)
// PORTS
//  iCLK         in   1   clock
//  iRST         in   1   reset, asynchronous, active-high
//  iFT_X        in   10  fingertip X, sampled only when iFT_VAL=1
//  iFT_Y        in   10  fingertip Y, sampled only when iFT_VAL=1
//  iFT_VAL      in   1   one-cycle pulse per frame, coordinates valid
//  iSEL_READY   in   1   game logic accepts oSEL_CELL
//  oSEL_CELL    out  4   selected cell, row*3+col (0..8)
//  oSEL_VALID   out  1   selection pending
//  oHOVER_CELL  out  4   current candidate cell; 4'hF = none
//  oDWELL       out  8   current dwell count
// BEHAVIOUR
//  - Reset (async): state IDLE; oSEL_VALID=0, oSEL_CELL=0, oHOVER_CELL=4'hF, oDWELL=0, lost_cnt=0.
//  - Cell decode is combinational from iFT_X/iFT_Y. All outputs are registered.
//  - All state changes happen only on edges where iFT_VAL=1, except the HOLD handshake.
//  - Lost sample: X>=SCREEN_W or Y>=SCREEN_H. A lost sample increments lost_cnt (saturating);
//    a non-lost sample clears lost_cnt.
//  - IDLE:
//    - Non-lost sample -> TRACK, with hover=cell and dwell=1.
//    - Lost sample -> stay in IDLE.
//  - TRACK:
//    - Same cell -> dwell+1.
//    - Different cell -> hover=new cell, dwell=1 (stay TRACK).
//    - Lost with lost_cnt+1 <= LOST_FRAMES -> dwell and hover held.
//    - Lost with lost_cnt+1 > LOST_FRAMES -> IDLE, hover=F, dwell=0.
//    - When the incremented dwell reaches DWELL_FRAMES -> HOLD.
//      oSEL_CELL=hover and oSEL_VALID=1 from the edge of that sample; visible the next cycle.
//  - HOLD:
//    - oSEL_VALID and oSEL_CELL are held stable; iFT_VAL is ignored.
//    - On an edge with iSEL_READY=1: oSEL_VALID=0 and go to RELEASE; dwell=0, lost_cnt=0.
//    - iSEL_READY=1 on the same edge that sets oSEL_VALID is not a handshake.
//  - RELEASE (re-arm guard, no new select):
//    - Same cell as oSEL_CELL -> stay.
//    - Different non-lost cell -> TRACK, hover=cell, dwell=1.
//    - Lost samples beyond LOST_FRAMES -> IDLE.
//  - oDWELL saturates at 255 and is never wider than 8 bits.
//  - Reset mid-HOLD drops oSEL_VALID immediately; a pending selection is discarded.
// TESTING
//  1. Assert reset -> oSEL_VALID=0, oHOVER_CELL=F, oDWELL=0. Then iFT_VAL with X=640 -> still IDLE, hover=F.
//  2. 15 frames at (100,100) -> oSEL_CELL=0 and oSEL_VALID=1 one cycle after the 15th pulse.
//     Hold iSEL_READY=0 for 10 cycles -> still valid. Raise ready -> oSEL_VALID=0 the next cycle.
//  3. After test 2, 20 more frames at (100,100) -> no select. Then 15 frames at (300,400) -> oSEL_CELL=7.
//  4. (320,240) x10, 2 lost, x5 -> select cell 4 on the 5th.
//     Repeat with 3 lost -> hover=F, 15 fresh frames are needed.
//  5. Boundaries:
//     - X=212 -> col0; X=213 -> col1; X=426 -> col2.
//     - Y=479 -> row2; X=639,Y=479 -> cell 8; Y=480 -> lost.
//  6. Alternate cells 0/1 every frame for 40 frames -> oDWELL never >1, no select.
//     Reset asserted mid-HOLD -> oSEL_VALID=0 asynchronously.

Source files
------------

// File: rtl/ft_cell_selector_if.sv
// Fingertip sample input and cell-select handshake bundle for ft_cell_selector.
interface ft_cell_selector_if;
  logic [9:0] iFT_X;
  logic [9:0] iFT_Y;
  logic       iFT_VAL;
  logic       iSEL_READY;
  logic [3:0] oSEL_CELL;
  logic       oSEL_VALID;
  logic [3:0] oHOVER_CELL;
  logic [7:0] oDWELL;

  // Upstream/consumer side: drives samples and ready, observes selection.
  modport master (
    output iFT_X, iFT_Y, iFT_VAL, iSEL_READY,
    input  oSEL_CELL, oSEL_VALID, oHOVER_CELL, oDWELL
  );

  // Selector side.
  modport slave (
    input  iFT_X, iFT_Y, iFT_VAL, iSEL_READY,
    output oSEL_CELL, oSEL_VALID, oHOVER_CELL, oDWELL
  );
endinterface

// File: rtl/ft_cell_selector.sv
// Maps fingertip samples onto a 3x3 grid, debounces with a dwell counter and
// issues one valid/ready cell-select event per deliberate hover.
module ft_cell_selector #(
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned SCREEN_H     = 480,
  parameter int unsigned COL_B0       = 213,
  parameter int unsigned COL_B1       = 426,
  parameter int unsigned ROW_B0       = 160,
  parameter int unsigned ROW_B1       = 320,
  parameter int unsigned DWELL_FRAMES = 15,
  parameter int unsigned LOST_FRAMES  = 2
) (
  input  logic               iCLK,
  input  logic               iRST,
  ft_cell_selector_if.slave  bus
);

  localparam int unsigned CW = 10;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 4;
  localparam logic [3:0]  NO_CELL = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRACK   = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    hover_q, hover_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [LW-1:0] lost_q, lost_d;
  logic [3:0]    sel_cell_q, sel_cell_d;
  logic          sel_valid_q, sel_valid_d;

  logic [1:0]    col_c, row_c;
  logic [3:0]    cell_c;
  logic          lost_c;
  logic [LW-1:0] lost_inc_c;
  logic          lost_over_c;
  logic [DW-1:0] dwell_inc_c;

  // Combinational grid decode and lost-sample detection.
  always_comb begin
    if (bus.iFT_X < CW'(COL_B0))      col_c = 2'd0;
    else if (bus.iFT_X < CW'(COL_B1)) col_c = 2'd1;
    else                              col_c = 2'd2;
    if (bus.iFT_Y < CW'(ROW_B0))      row_c = 2'd0;
    else if (bus.iFT_Y < CW'(ROW_B1)) row_c = 2'd1;
    else                              row_c = 2'd2;
    cell_c      = ({2'b00, row_c} * 4'd3) + {2'b00, col_c};
    lost_c      = (bus.iFT_X >= CW'(SCREEN_W)) || (bus.iFT_Y >= CW'(SCREEN_H));
    lost_inc_c  = (lost_q == {LW{1'b1}}) ? lost_q : lost_q + LW'(1);
    lost_over_c = ((LW + 1)'(lost_q) + (LW + 1)'(1)) > (LW + 1)'(LOST_FRAMES);
    dwell_inc_c = (dwell_q == {DW{1'b1}}) ? dwell_q : dwell_q + DW'(1);
  end

  // Next-state and output-register computation.
  always_comb begin
    state_d     = state_q;
    hover_d     = hover_q;
    dwell_d     = dwell_q;
    lost_d      = lost_q;
    sel_cell_d  = sel_cell_q;
    sel_valid_d = sel_valid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.iFT_VAL) begin
          if (lost_c) begin
            lost_d = lost_inc_c;
          end else begin
            lost_d  = '0;
            state_d = TRACK;
            hover_d = cell_c;
            dwell_d = DW'(1);
          end
        end
      end

      TRACK: begin
        if (bus.iFT_VAL) begin
          if (lost_c) begin
            lost_d = lost_inc_c;
            if (lost_over_c) begin
              state_d = IDLE;
              hover_d = NO_CELL;
              dwell_d = '0;
            end
          end else begin
            lost_d = '0;
            if (cell_c == hover_q) begin
              dwell_d = dwell_inc_c;
            end else begin
              hover_d = cell_c;
              dwell_d = DW'(1);
            end
            if (dwell_d == DW'(DWELL_FRAMES)) begin
              state_d     = HOLD;
              sel_cell_d  = hover_d;
              sel_valid_d = 1'b1;
            end
          end
        end
      end

      HOLD: begin
        // Samples are ignored until game logic takes the selection.
        if (bus.iSEL_READY) begin
          sel_valid_d = 1'b0;
          state_d     = RELEASE;
          dwell_d     = '0;
          lost_d      = '0;
        end
      end

      RELEASE: begin
        // Re-arm guard: the finger must leave the selected cell before tracking again.
        if (bus.iFT_VAL) begin
          if (lost_c) begin
            lost_d = lost_inc_c;
            if (lost_over_c) begin
              state_d = IDLE;
              hover_d = NO_CELL;
              dwell_d = '0;
            end
          end else begin
            lost_d = '0;
            if (cell_c != sel_cell_q) begin
              state_d = TRACK;
              hover_d = cell_c;
              dwell_d = DW'(1);
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q     <= IDLE;
      hover_q     <= NO_CELL;
      dwell_q     <= '0;
      lost_q      <= '0;
      sel_cell_q  <= '0;
      sel_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hover_q     <= hover_d;
      dwell_q     <= dwell_d;
      lost_q      <= lost_d;
      sel_cell_q  <= sel_cell_d;
      sel_valid_q <= sel_valid_d;
    end
  end

  assign bus.oSEL_CELL   = sel_cell_q;
  assign bus.oSEL_VALID  = sel_valid_q;
  assign bus.oHOVER_CELL = hover_q;
  assign bus.oDWELL      = dwell_q;

endmodule
